// File: rtl/combo_entry.sv
// Combination entry/check engine: cursor + per-digit up/down edit, submit compares against code.
// Latency: one cycle from any input pulse to the registered outputs.
// Backpressure: none; every input pulse acts once per cycle it is high. Lockout via COMBO_LOCKOUT_EN.
module combo_entry #(
    parameter int NUM_DIGITS     = 4,
    parameter int DIGIT_MAX      = 9,
    parameter int MAX_TRIES      = 3,
    parameter int LOCKOUT_CYCLES = 100000000,
    localparam int CW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1,
    localparam int DW = 4 * NUM_DIGITS
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          inc_i,
    input  logic          dec_i,
    input  logic          left_i,
    input  logic          right_i,
    input  logic          clr_i,
    input  logic          submit_i,
    input  logic [DW-1:0] code_i,
    output logic [DW-1:0] digits_o,
    output logic [CW-1:0] cursor_o,
    output logic          unlocked_o,
    output logic          locked_out_o,
    output logic          fail_pulse_o,
    output logic [3:0]    fail_count_o
);

    typedef enum logic [1:0] {
        ST_ENTRY    = 2'd0,
        ST_UNLOCKED = 2'd1,
        ST_LOCKOUT  = 2'd2
    } state_t;

    localparam logic [3:0]    DMAX  = 4'(DIGIT_MAX);
    localparam logic [CW-1:0] CLAST = CW'(NUM_DIGITS - 1);

    state_t        state_q;
    logic [DW-1:0] digits_q;
    logic [CW-1:0] cursor_q;
    logic          unlocked_q;
    logic          fail_pulse_q;
    logic [3:0]    fail_q;

    logic [3:0]    sel_dig;
    logic [3:0]    sel_nxt;
    logic [DW-1:0] edit_digits_d;
    logic [CW-1:0] edit_cursor_d;
    logic [3:0]    fail_inc;

`ifdef COMBO_LOCKOUT_EN
    localparam int             LCW  = (LOCKOUT_CYCLES > 1) ? $clog2(LOCKOUT_CYCLES) : 1;
    localparam logic [LCW-1:0] LAST = LCW'(LOCKOUT_CYCLES - 1);
    logic [LCW-1:0] lock_cnt_q;
    logic           locked_q;
    assign locked_out_o = locked_q;
`else
    assign locked_out_o = 1'b0;
`endif

    assign fail_inc = (fail_q == 4'hF) ? 4'hF : fail_q + 4'd1;

    // Entry-mode edit result: the edit uses the cursor before the move takes effect.
    always_comb begin
        sel_dig = 4'd0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (cursor_q == CW'(i)) sel_dig = digits_q[4*i +: 4];
        end
        sel_nxt = sel_dig;
        if (inc_i && !dec_i)      sel_nxt = (sel_dig == DMAX) ? 4'd0 : sel_dig + 4'd1;
        else if (dec_i && !inc_i) sel_nxt = (sel_dig == 4'd0) ? DMAX : sel_dig - 4'd1;
        edit_digits_d = digits_q;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (cursor_q == CW'(i)) edit_digits_d[4*i +: 4] = sel_nxt;
        end
        edit_cursor_d = cursor_q;
        if (left_i && !right_i)      edit_cursor_d = (cursor_q == CLAST) ? '0 : cursor_q + CW'(1);
        else if (right_i && !left_i) edit_cursor_d = (cursor_q == '0) ? CLAST : cursor_q - CW'(1);
    end

    // Main state machine; all outputs are registered here.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= ST_ENTRY;
            digits_q     <= '0;
            cursor_q     <= '0;
            unlocked_q   <= 1'b0;
            fail_pulse_q <= 1'b0;
            fail_q       <= 4'd0;
`ifdef COMBO_LOCKOUT_EN
            locked_q     <= 1'b0;
            lock_cnt_q   <= '0;
`endif
        end else begin
            fail_pulse_q <= 1'b0;
            case (state_q)
                ST_ENTRY: begin
                    if (clr_i) begin
                        digits_q <= '0;
                        cursor_q <= '0;
                        fail_q   <= 4'd0;
                    end else if (submit_i) begin
                        if (digits_q == code_i) begin
                            state_q    <= ST_UNLOCKED;
                            unlocked_q <= 1'b1;
                            fail_q     <= 4'd0;
                        end else begin
                            fail_pulse_q <= 1'b1;
                            fail_q       <= fail_inc;
                            digits_q     <= '0;
                            cursor_q     <= '0;
`ifdef COMBO_LOCKOUT_EN
                            if (int'(fail_inc) >= MAX_TRIES) begin
                                state_q    <= ST_LOCKOUT;
                                locked_q   <= 1'b1;
                                lock_cnt_q <= '0;
                            end
`endif
                        end
                    end else begin
                        digits_q <= edit_digits_d;
                        cursor_q <= edit_cursor_d;
                    end
                end
                ST_UNLOCKED: begin
                    if (clr_i) begin
                        state_q    <= ST_ENTRY;
                        unlocked_q <= 1'b0;
                        digits_q   <= '0;
                        cursor_q   <= '0;
                        fail_q     <= 4'd0;
                    end
                end
`ifdef COMBO_LOCKOUT_EN
                ST_LOCKOUT: begin
                    if (lock_cnt_q == LAST) begin
                        state_q  <= ST_ENTRY;
                        locked_q <= 1'b0;
                        fail_q   <= 4'd0;
                        digits_q <= '0;
                        cursor_q <= '0;
                    end else begin
                        lock_cnt_q <= lock_cnt_q + LCW'(1);
                    end
                end
`endif
                default: begin
                    state_q    <= ST_ENTRY;
                    unlocked_q <= 1'b0;
                end
            endcase
        end
    end

    assign digits_o     = digits_q;
    assign cursor_o     = cursor_q;
    assign unlocked_o   = unlocked_q;
    assign fail_pulse_o = fail_pulse_q;
    assign fail_count_o = fail_q;

endmodule

// File: tb/tb_combo_entry.sv
// Bench for combo_entry: directed scenarios plus random stimulus against a digit-array model.
// Inputs change on the falling edge; outputs are checked on the falling edge after each rising edge.
// Lockout scenarios are selected by COMBO_LOCKOUT_EN, matching the DUT build.
module tb_combo_entry;

    localparam int ND = 4;
    localparam int DM = 9;
    localparam int MT = 3;
    localparam int LC = 8;
`ifdef COMBO_LOCKOUT_EN
    localparam bit LOCK_EN = 1'b1;
`else
    localparam bit LOCK_EN = 1'b0;
`endif

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        inc_i = 1'b0, dec_i = 1'b0, left_i = 1'b0, right_i = 1'b0;
    logic        clr_i = 1'b0, submit_i = 1'b0;
    logic [15:0] code_i = 16'h0;
    logic [15:0] digits_o;
    logic [1:0]  cursor_o;
    logic        unlocked_o, locked_out_o, fail_pulse_o;
    logic [3:0]  fail_count_o;
    logic [24:0] dut_outs;

    int checks = 0;
    int passed = 0;

    always #5 clk_i = ~clk_i;

    combo_entry #(
        .NUM_DIGITS(ND), .DIGIT_MAX(DM), .MAX_TRIES(MT), .LOCKOUT_CYCLES(LC)
    ) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .inc_i(inc_i), .dec_i(dec_i),
        .left_i(left_i), .right_i(right_i), .clr_i(clr_i), .submit_i(submit_i),
        .code_i(code_i), .digits_o(digits_o), .cursor_o(cursor_o),
        .unlocked_o(unlocked_o), .locked_out_o(locked_out_o),
        .fail_pulse_o(fail_pulse_o), .fail_count_o(fail_count_o)
    );

    assign dut_outs = {digits_o, cursor_o, unlocked_o, locked_out_o, fail_pulse_o, fail_count_o};

    // Reference model: digits as an integer array, state as 0=entry 1=unlocked 2=lockout.
    int m_dig[ND];
    int m_cur, m_fail, m_state, m_left;
    bit m_pulse;

    function automatic logic [15:0] m_digits();
        logic [15:0] v;
        v = '0;
        for (int i = 0; i < ND; i++) v[4*i +: 4] = 4'(m_dig[i]);
        return v;
    endfunction

    function automatic logic [24:0] m_outs();
        return {m_digits(), 2'(m_cur), (m_state == 1), (m_state == 2), m_pulse, 4'(m_fail)};
    endfunction

    task automatic model_clear_entry();
        for (int i = 0; i < ND; i++) m_dig[i] = 0;
        m_cur = 0;
    endtask

    task automatic model_reset();
        model_clear_entry();
        m_fail = 0; m_state = 0; m_left = 0; m_pulse = 0;
    endtask

    task automatic model_step(input bit a_inc, a_dec, a_left, a_right, a_clr, a_sub);
        bit match;
        int old;
        m_pulse = 0;
        if (m_state == 0) begin
            if (a_clr) begin
                model_clear_entry();
                m_fail = 0;
            end else if (a_sub) begin
                match = 1;
                for (int i = 0; i < ND; i++) if (int'(code_i[4*i +: 4]) != m_dig[i]) match = 0;
                if (match) begin
                    m_state = 1;
                    m_fail = 0;
                end else begin
                    m_pulse = 1;
                    m_fail = (m_fail >= 15) ? 15 : m_fail + 1;
                    model_clear_entry();
                    if (LOCK_EN && m_fail >= MT) begin
                        m_state = 2;
                        m_left = LC;
                    end
                end
            end else begin
                old = m_cur;
                if (a_inc && !a_dec) m_dig[old] = (m_dig[old] + 1) % (DM + 1);
                if (a_dec && !a_inc) m_dig[old] = (m_dig[old] + DM) % (DM + 1);
                if (a_left && !a_right) m_cur = (m_cur + 1) % ND;
                if (a_right && !a_left) m_cur = (m_cur + ND - 1) % ND;
            end
        end else if (m_state == 1) begin
            if (a_clr) begin
                m_state = 0;
                model_clear_entry();
                m_fail = 0;
            end
        end else begin
            m_left = m_left - 1;
            if (m_left == 0) begin
                m_state = 0;
                m_fail = 0;
                model_clear_entry();
            end
        end
    endtask

    // One clock: drive pulses from a falling edge, step the model at the rising edge, release at the next falling edge.
    task automatic tick(input bit a_inc, a_dec, a_left, a_right, a_clr, a_sub);
        inc_i = a_inc; dec_i = a_dec; left_i = a_left; right_i = a_right;
        clr_i = a_clr; submit_i = a_sub;
        @(posedge clk_i);
        model_step(a_inc, a_dec, a_left, a_right, a_clr, a_sub);
        @(negedge clk_i);
        inc_i = 0; dec_i = 0; left_i = 0; right_i = 0; clr_i = 0; submit_i = 0;
    endtask

    task automatic apply_reset();
        rst_ni = 1'b0;
        model_reset();
        repeat (2) @(negedge clk_i);
        rst_ni = 1'b1;
    endtask

    task automatic enter_1234();
        repeat (4) tick(1, 0, 0, 0, 0, 0);
        tick(0, 0, 1, 0, 0, 0);
        repeat (3) tick(1, 0, 0, 0, 0, 0);
        tick(0, 0, 1, 0, 0, 0);
        repeat (2) tick(1, 0, 0, 0, 0, 0);
        tick(0, 0, 1, 0, 0, 0);
        tick(1, 0, 0, 0, 0, 0);
    endtask

    task automatic test_reset();
        rst_ni = 1'b0;
        model_reset();
        inc_i = 1'b1;
        repeat (3) @(negedge clk_i);
        checks++; if (dut_outs !== 25'h0) $display("FAIL reset_outs got %h exp %h", dut_outs, 25'h0); else passed++;
        inc_i = 1'b0;
        rst_ni = 1'b1;
        tick(0, 0, 0, 0, 0, 0);
        checks++; if (dut_outs !== m_outs()) $display("FAIL reset_idle got %h exp %h", dut_outs, m_outs()); else passed++;
    endtask

    task automatic test_wrap();
        apply_reset();
        tick(0, 1, 0, 0, 0, 0);
        checks++; if (digits_o !== 16'h0009) $display("FAIL wrap_dec got %h exp %h", digits_o, 16'h0009); else passed++;
        tick(1, 0, 0, 0, 0, 0);
        checks++; if (digits_o !== 16'h0000) $display("FAIL wrap_inc got %h exp %h", digits_o, 16'h0000); else passed++;
        tick(0, 0, 0, 1, 0, 0);
        checks++; if (cursor_o !== 2'd3) $display("FAIL wrap_right got %0d exp %0d", cursor_o, 3); else passed++;
        tick(0, 0, 1, 0, 0, 0);
        tick(0, 0, 1, 0, 0, 0);
        checks++; if (cursor_o !== 2'd1) $display("FAIL wrap_left got %0d exp %0d", cursor_o, 1); else passed++;
    endtask

    task automatic test_unlock();
        apply_reset();
        code_i = 16'h1234;
        enter_1234();
        checks++; if (digits_o !== 16'h1234) $display("FAIL unlock_entry got %h exp %h", digits_o, 16'h1234); else passed++;
        tick(0, 0, 0, 0, 0, 1);
        checks++; if ({unlocked_o, fail_count_o, fail_pulse_o} !== 6'b1_0000_0)
            $display("FAIL unlock_submit got %b exp %b", {unlocked_o, fail_count_o, fail_pulse_o}, 6'b1_0000_0); else passed++;
        code_i = 16'h9999;
        tick(1, 0, 0, 0, 0, 0);
        tick(0, 0, 0, 0, 0, 1);
        tick(0, 1, 1, 0, 0, 0);
        checks++; if ({digits_o, unlocked_o, fail_pulse_o} !== {16'h1234, 2'b10})
            $display("FAIL unlock_hold got %h exp %h", {digits_o, unlocked_o, fail_pulse_o}, {16'h1234, 2'b10}); else passed++;
        tick(0, 0, 0, 0, 1, 0);
        checks++; if ({digits_o, cursor_o, unlocked_o} !== 19'h0)
            $display("FAIL unlock_clr got %h exp %h", {digits_o, cursor_o, unlocked_o}, 19'h0); else passed++;
    endtask

    task automatic test_simultaneous();
        apply_reset();
        code_i = 16'h1234;
        tick(1, 0, 0, 0, 0, 0);
        tick(1, 1, 0, 0, 0, 0);
        checks++; if (digits_o !== 16'h0001) $display("FAIL sim_incdec got %h exp %h", digits_o, 16'h0001); else passed++;
        tick(0, 0, 1, 1, 0, 0);
        checks++; if (cursor_o !== 2'd0) $display("FAIL sim_leftright got %0d exp %0d", cursor_o, 0); else passed++;
        tick(0, 0, 0, 0, 1, 1);
        checks++; if ({digits_o, fail_pulse_o, fail_count_o} !== 21'h0)
            $display("FAIL sim_clrsubmit got %h exp %h", {digits_o, fail_pulse_o, fail_count_o}, 21'h0); else passed++;
        tick(1, 0, 1, 0, 0, 0);
        checks++; if ({digits_o, cursor_o} !== {16'h0001, 2'd1})
            $display("FAIL sim_incleft got %h exp %h", {digits_o, cursor_o}, {16'h0001, 2'd1}); else passed++;
    endtask

`ifdef COMBO_LOCKOUT_EN
    task automatic test_lockout();
        int cnt;
        apply_reset();
        code_i = 16'h1234;
        for (int k = 1; k <= MT; k++) begin
            tick(0, 0, 0, 0, 0, 1);
            checks++; if ({fail_pulse_o, fail_count_o, locked_out_o} !== {1'b1, 4'(k), (k == MT)})
                $display("FAIL lock_submit%0d got %b exp %b", k, {fail_pulse_o, fail_count_o, locked_out_o}, {1'b1, 4'(k), (k == MT)}); else passed++;
            if (k < MT) begin
                tick(0, 0, 0, 0, 0, 0);
                checks++; if (fail_pulse_o !== 1'b0) $display("FAIL lock_pulse_drop%0d got %b exp 0", k, fail_pulse_o); else passed++;
            end
        end
        cnt = 1;
        for (int c = 0; c < 40; c++) begin
            tick(0, 0, 0, 0, 1, 0);
            if (locked_out_o === 1'b1) cnt++;
            else break;
        end
        checks++; if (cnt != LC) $display("FAIL lock_duration got %0d exp %0d", cnt, LC); else passed++;
        checks++; if ({fail_count_o, unlocked_o, locked_out_o, digits_o} !== 22'h0)
            $display("FAIL lock_exit got %h exp %h", {fail_count_o, unlocked_o, locked_out_o, digits_o}, 22'h0); else passed++;
        tick(1, 0, 0, 0, 0, 0);
        checks++; if (digits_o !== 16'h0001) $display("FAIL lock_editable got %h exp %h", digits_o, 16'h0001); else passed++;
    endtask

    task automatic test_reset_mid_lockout();
        apply_reset();
        code_i = 16'h1234;
        repeat (MT) tick(0, 0, 0, 0, 0, 1);
        repeat (3) tick(0, 0, 0, 0, 0, 0);
        checks++; if (locked_out_o !== 1'b1) $display("FAIL rstlock_pre got %b exp 1", locked_out_o); else passed++;
        #2;
        rst_ni = 1'b0;
        model_reset();
        #1;
        checks++; if (dut_outs !== 25'h0) $display("FAIL rstlock_async got %h exp %h", dut_outs, 25'h0); else passed++;
        @(negedge clk_i);
        rst_ni = 1'b1;
        enter_1234();
        tick(0, 0, 0, 0, 0, 1);
        checks++; if ({unlocked_o, locked_out_o} !== 2'b10) $display("FAIL rstlock_unlock got %b exp %b", {unlocked_o, locked_out_o}, 2'b10); else passed++;
    endtask
`else
    task automatic test_no_lockout();
        apply_reset();
        code_i = 16'h1234;
        repeat (4) tick(0, 0, 0, 0, 0, 1);
        checks++; if ({fail_count_o, locked_out_o, fail_pulse_o} !== {4'd4, 2'b01})
            $display("FAIL nolock_fails got %b exp %b", {fail_count_o, locked_out_o, fail_pulse_o}, {4'd4, 2'b01}); else passed++;
        tick(1, 0, 0, 0, 0, 0);
        checks++; if ({digits_o, locked_out_o} !== {16'h0001, 1'b0})
            $display("FAIL nolock_editable got %h exp %h", {digits_o, locked_out_o}, {16'h0001, 1'b0}); else passed++;
    endtask

    task automatic test_reset_mid_entry();
        apply_reset();
        code_i = 16'h1234;
        tick(0, 0, 0, 0, 0, 1);
        tick(1, 0, 1, 0, 0, 0);
        #2;
        rst_ni = 1'b0;
        model_reset();
        #1;
        checks++; if (dut_outs !== 25'h0) $display("FAIL rstentry_async got %h exp %h", dut_outs, 25'h0); else passed++;
        @(negedge clk_i);
        rst_ni = 1'b1;
        enter_1234();
        tick(0, 0, 0, 0, 0, 1);
        checks++; if (unlocked_o !== 1'b1) $display("FAIL rstentry_unlock got %b exp 1", unlocked_o); else passed++;
    endtask
`endif

    task automatic test_random();
        bit r_inc, r_dec, r_left, r_right, r_clr, r_sub;
        int bad;
        apply_reset();
        bad = 0;
        for (int n = 0; n < 600; n++) begin
            case ($urandom_range(0, 9))
                0, 1:    code_i = m_digits();
                2:       code_i = 16'($urandom);
                default: ;
            endcase
            r_inc   = ($urandom_range(0, 3) == 0);
            r_dec   = ($urandom_range(0, 3) == 0);
            r_left  = ($urandom_range(0, 3) == 0);
            r_right = ($urandom_range(0, 3) == 0);
            r_clr   = ($urandom_range(0, 31) == 0);
            r_sub   = ($urandom_range(0, 11) == 0);
            tick(r_inc, r_dec, r_left, r_right, r_clr, r_sub);
            checks++;
            if (dut_outs !== m_outs()) begin
                if (bad < 10) $display("FAIL random cycle %0d got %h exp %h", n, dut_outs, m_outs());
                bad++;
            end else passed++;
        end
    endtask

    initial begin
        test_reset();
        test_wrap();
        test_unlock();
        test_simultaneous();
`ifdef COMBO_LOCKOUT_EN
        test_lockout();
        test_reset_mid_lockout();
`else
        test_no_lockout();
        test_reset_mid_entry();
`endif
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired got timeout exp completion");
        $fatal(1, "watchdog");
    end

endmodule
